// File: rtl/pipe_adder.sv
// pipe_adder: two-stage pipelined add / subtract / accumulate unit with
// valid/ready handshakes on both sides. Stage 1 registers the operand pair
// and mode. Stage 2 computes the result into the output registers and the
// running accumulator. A single enable freezes the whole pipeline whenever
// the output holds a result that downstream has not yet taken.
module pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] DOut1,
  input  logic [WIDTH-1:0] DOut2,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ADDOut,
  output logic             carry
);

  localparam logic SAT_ON = (SAT != 32'sd0);

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Pipeline enable
  logic en_s;

  // Stage-1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       mode_q, mode_d;

  // Stage-2 / output registers and accumulator
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] addout_q, addout_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Arithmetic intermediates
  logic [WIDTH:0]   raw_s;
  logic             raw_c_s;
  logic [WIDTH-1:0] res_s;

  // Pipeline advances unless a result is stuck at the output; this is the only out_ready -> in_ready path.
  always_comb begin
    en_s = !out_valid_q || out_ready;
  end

  assign in_ready  = en_s;
  assign out_valid = out_valid_q;
  assign ADDOut    = addout_q;
  assign carry     = carry_q;

  // Stage-1 next state: capture the operand pair on an input transfer, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    if (en_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d    = DOut1;
        b_d    = DOut2;
        mode_d = mode;
      end else begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Raw (WIDTH+1)-bit result; the top bit is carry for add/acc and borrow for sub.
  always_comb begin
    raw_s = {1'b0, a_q};
    case (mode_q)
      MODE_ADD:  raw_s = {1'b0, a_q} + {1'b0, b_q};
      MODE_SUB:  raw_s = {1'b0, a_q} - {1'b0, b_q};
      MODE_ACC:  raw_s = {1'b0, acc_q} + {1'b0, a_q};
      MODE_LOAD: raw_s = {1'b0, a_q};
      default:   raw_s = {1'b0, a_q};
    endcase
  end

  // Optional unsigned saturation: overflow clamps high, borrow clamps to zero.
  always_comb begin
    raw_c_s = raw_s[WIDTH];
    res_s   = raw_s[WIDTH-1:0];
    if (SAT_ON && raw_c_s) begin
      if (mode_q == MODE_SUB) begin
        res_s = {WIDTH{1'b0}};
      end else begin
        res_s = {WIDTH{1'b1}};
      end
    end else begin
      res_s = raw_s[WIDTH-1:0];
    end
  end

  // Stage-2 next state: load result/carry when stage 1 holds an item; accumulate modes also commit to acc.
  always_comb begin
    out_valid_d = out_valid_q;
    addout_d    = addout_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    if (en_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        addout_d = res_s;
        carry_d  = raw_c_s;
        if (mode_q[1]) begin
          acc_d = res_s;
        end else begin
          acc_d = acc_q;
        end
      end else begin
        addout_d = addout_q;
        carry_d  = carry_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-high reset clearing everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      addout_q    <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      addout_q    <= addout_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
    end
  end

endmodule
